// File: rtl/vlsu_pkg.sv
// vlsu_pkg
// Shared types and defaults for the vector load/store unit.
//   state_t          : access sequencer states (IDLE, BEAT, DRAIN)
//   lane_idx_t       : lane/beat index for the default lane count
//   ADDR_MAX_DEFAULT : highest legal byte address of the data memory
package vlsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEFAULT_LANES = 4;
  // A single-lane unit still needs a one-bit index.
  localparam int DEFAULT_IDX_W = (DEFAULT_LANES > 1) ? $clog2(DEFAULT_LANES) : 1;

  typedef logic [DEFAULT_IDX_W-1:0] lane_idx_t;

  localparam logic [31:0] ADDR_MAX_DEFAULT = 32'h3D08F;

endpackage

// File: rtl/vlsu_addr_gen.sv
// vlsu_addr_gen
// Beat address generator: base/stride accumulator plus range clamp.
//   clk, rst      : clock, synchronous active-high reset
//   use_live      : 1 = present base_addr directly (acceptance / scalar cycle)
//   start         : accept an access; latch stride and the next beat address
//   start_stride  : 1 = next address is base+stride, 0 = hold base (drain)
//   step          : advance the held address by the latched stride
//   base_addr     : lane-0 byte address
//   stride        : byte distance between lanes (unsigned, wraps mod 2^N)
//   addr          : clamped beat address (0 when out of range)
//   fault         : current beat address exceeds ADDR_MAX
module vlsu_addr_gen #(
  parameter int          N        = 32,
  parameter logic [31:0] ADDR_MAX = 32'h3D08F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         use_live,
  input  logic         start,
  input  logic         start_stride,
  input  logic         step,
  input  logic [N-1:0] base_addr,
  input  logic [N-1:0] stride,
  output logic [N-1:0] addr,
  output logic         fault
);

  localparam logic [N-1:0] LIMIT = N'(ADDR_MAX);

  logic [N-1:0] addr_reg;
  logic [N-1:0] stride_reg;
  logic [N-1:0] raw_addr;

  // Incremental address: only an adder, no multiplier, per beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg   <= '0;
      stride_reg <= '0;
    end else if (start) begin
      stride_reg <= stride;
      addr_reg   <= start_stride ? (base_addr + stride) : base_addr;
    end else if (step) begin
      addr_reg <= addr_reg + stride_reg;
    end
  end

  assign raw_addr = use_live ? base_addr : addr_reg;
  assign fault    = (raw_addr > LIMIT);
  assign addr     = fault ? '0 : raw_addr;

endmodule

// File: rtl/vector_lsu.sv
// vector_lsu
// MEM-stage load/store unit: splits a LANES x N-bit vector access into one
// memory beat per lane (strided, masked, range-clamped) and stalls the
// pipeline until the access completes. Scalar accesses pass straight through.
//   clk, rst        : clock, synchronous active-high reset
//   op_store/op_load: request type (store wins if both are set)
//   op_vector       : 1 = vector access, 0 = scalar
//   base_addr       : lane-0 byte address;  stride: byte step between lanes
//   lane_mask       : per-lane enable;      store_data: LANES packed lanes
//   mem_rdata       : data memory read data (READ_LATENCY 0 or 1)
//   stall           : freezes PC and pipe registers
//   mem_wen/mem_addr/mem_wdata : data memory write port / address
//   load_vector     : load result to MEM/WB
//   addr_fault      : pulse for a beat whose address exceeded ADDR_MAX
module vector_lsu
  import vlsu_pkg::*;
#(
  parameter int          N            = 32,
  parameter int          LANES        = 4,
  parameter logic [31:0] ADDR_MAX     = ADDR_MAX_DEFAULT,
  parameter int          READ_LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_store,
  input  logic                 op_load,
  input  logic                 op_vector,
  input  logic [N-1:0]         base_addr,
  input  logic [N-1:0]         stride,
  input  logic [LANES-1:0]     lane_mask,
  input  logic [N*LANES-1:0]   store_data,
  input  logic [N-1:0]         mem_rdata,
  output logic                 stall,
  output logic                 mem_wen,
  output logic [N-1:0]         mem_addr,
  output logic [N-1:0]         mem_wdata,
  output logic [N*LANES-1:0]   load_vector,
  output logic                 addr_fault
);

  localparam int             V     = N * LANES;
  localparam int             KW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [KW-1:0]  LAST  = KW'(LANES - 1);
  localparam bit             MULTI = (LANES > 1);
  localparam bit             RL1   = (READ_LATENCY == 1);

  state_t          state_reg, state_next;
  logic [KW-1:0]   k_reg, k_next;

  // Request copies held for beats 1..LANES-1.
  logic            store_reg, load_reg, vec_reg;
  logic [LANES-1:0] mask_reg;
  logic [N-1:0]    data_reg  [LANES];
  logic [N-1:0]    lanes_reg [LANES];

  logic            req, is_store, is_load, accept_vec;
  logic            ag_use_live, ag_start, ag_start_stride, ag_step;
  logic [N-1:0]    cur_addr;
  logic            cur_fault;
  logic            cur_keep, beat_load, last_beat;
  logic            cap_en, cap_keep, pend_keep;
  logic [KW-1:0]   cap_idx;
  logic            bypass, zext;
  logic [N-1:0]    gated_rdata;

  assign is_store   = op_store;
  assign is_load    = op_load & ~op_store;
  assign req        = op_store | op_load;
  assign accept_vec = req & op_vector & MULTI;

  // Address generator controls depend only on state and request, keeping
  // them free of the clamp result.
  assign ag_use_live     = (state_reg == IDLE);
  assign ag_start        = (state_reg == IDLE) & (accept_vec | (RL1 & is_load));
  assign ag_start_stride = accept_vec;
  assign ag_step         = (state_reg == BEAT) & (k_reg != LAST);

  vlsu_addr_gen #(
    .N        (N),
    .ADDR_MAX (ADDR_MAX)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .use_live     (ag_use_live),
    .start        (ag_start),
    .start_stride (ag_start_stride),
    .step         (ag_step),
    .base_addr    (base_addr),
    .stride       (stride),
    .addr         (cur_addr),
    .fault        (cur_fault)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      store_reg <= 1'b0;
      load_reg  <= 1'b0;
      vec_reg   <= 1'b0;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      // Re-latched every idle cycle; frozen once an access is in flight.
      if (state_reg == IDLE) begin
        store_reg <= is_store;
        load_reg  <= is_load;
        vec_reg   <= op_vector;
        mask_reg  <= lane_mask;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    stall       = 1'b0;
    mem_wen     = 1'b0;
    mem_wdata   = '0;
    addr_fault  = 1'b0;
    cur_keep    = 1'b0;
    beat_load   = 1'b0;
    last_beat   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        // Beat 0 (or the scalar access) runs from the live inputs.
        cur_keep   = (~op_vector | lane_mask[0]) & ~cur_fault;
        mem_wdata  = store_data[N-1:0];
        mem_wen    = is_store & cur_keep;
        addr_fault = req & cur_fault;
        beat_load  = is_load;
        if (accept_vec) begin
          stall      = 1'b1;
          state_next = BEAT;
          k_next     = KW'(1);
        end else if (RL1 && is_load) begin
          stall      = 1'b1;
          state_next = DRAIN;
        end
      end
      BEAT: begin
        cur_keep   = mask_reg[k_reg] & ~cur_fault;
        mem_wdata  = data_reg[k_reg];
        mem_wen    = store_reg & cur_keep;
        addr_fault = cur_fault;
        beat_load  = load_reg;
        if (k_reg == LAST) begin
          last_beat  = 1'b1;
          k_next     = '0;
          stall      = RL1 & load_reg;
          state_next = (RL1 && load_reg) ? DRAIN : IDLE;
        end else begin
          stall  = 1'b1;
          k_next = k_reg + KW'(1);
        end
      end
      DRAIN: begin
        // Final read data arrives now; address is held, nothing is written.
        cur_keep   = pend_keep;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      state_next = IDLE;
      k_next     = '0;
      stall      = 1'b0;
      mem_wen    = 1'b0;
      mem_wdata  = '0;
      addr_fault = 1'b0;
      beat_load  = 1'b0;
      last_beat  = 1'b0;
    end
  end

  assign mem_addr = rst ? '0 : cur_addr;

  // Lane capture source: the beat itself at latency 0, or a one-deep
  // pipeline of (lane index, keep) at latency 1.
  generate
    if (READ_LATENCY == 1) begin : g_rl1
      logic          pend_valid_reg;
      logic [KW-1:0] pend_idx_reg;
      logic          pend_keep_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_valid_reg <= 1'b0;
          pend_idx_reg   <= '0;
          pend_keep_reg  <= 1'b0;
        end else begin
          pend_valid_reg <= beat_load;
          pend_idx_reg   <= k_reg;
          pend_keep_reg  <= cur_keep;
        end
      end
      assign cap_en    = pend_valid_reg;
      assign cap_idx   = pend_idx_reg;
      assign cap_keep  = pend_keep_reg;
      assign pend_keep = pend_keep_reg;
    end else begin : g_rl0
      assign cap_en    = beat_load;
      assign cap_idx   = k_reg;
      assign cap_keep  = cur_keep;
      assign pend_keep = 1'b0;
    end
  endgenerate

  assign gated_rdata = cur_keep ? mem_rdata : '0;
  // Completion cycle: the last lane bypasses its register.
  assign bypass = (!RL1 && last_beat && load_reg) || ((state_reg == DRAIN) && vec_reg);
  assign zext   = (state_reg == IDLE) || ((state_reg == DRAIN) && !vec_reg);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg[gi]  <= '0;
          lanes_reg[gi] <= '0;
        end else begin
          if (state_reg == IDLE)
            data_reg[gi] <= store_data[gi*N +: N];
          if (cap_en && (cap_idx == KW'(gi)))
            lanes_reg[gi] <= cap_keep ? mem_rdata : '0;
        end
      end

      always_comb begin
        if (rst)
          load_vector[gi*N +: N] = '0;
        else if (zext)
          load_vector[gi*N +: N] = (gi == 0) ? gated_rdata : '0;
        else if (bypass && (gi == LANES - 1))
          load_vector[gi*N +: N] = gated_rdata;
        else
          load_vector[gi*N +: N] = lanes_reg[gi];
      end
    end
  endgenerate

endmodule

// File: tb/tb_vector_lsu.sv
// tb_vector_lsu
// Scoreboard bench: two units (read latency 0 and 1) each with a word memory.
// Each request pushes one expected entry per cycle; a negedge monitor pops
// and compares against the selected unit.
module tb_vector_lsu;

  localparam logic [31:0] AMAX = 32'h3D08F;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_store0, op_load0, op_store1, op_load1, op_vector;
  logic [31:0]  base_addr, stride;
  logic [3:0]   lane_mask;
  logic [127:0] store_data;
  logic [31:0]  mem_rdata0, mem_rdata1;
  logic         stall0, mem_wen0, addr_fault0, stall1, mem_wen1, addr_fault1;
  logic [31:0]  mem_addr0, mem_wdata0, mem_addr1, mem_wdata1;
  logic [127:0] load_vector0, load_vector1;

  always #5 clk = ~clk;

  vector_lsu #(.N(32), .LANES(4), .ADDR_MAX(AMAX), .READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .op_store(op_store0), .op_load(op_load0),
    .op_vector(op_vector), .base_addr(base_addr), .stride(stride),
    .lane_mask(lane_mask), .store_data(store_data), .mem_rdata(mem_rdata0),
    .stall(stall0), .mem_wen(mem_wen0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .load_vector(load_vector0), .addr_fault(addr_fault0)
  );

  vector_lsu #(.N(32), .LANES(4), .ADDR_MAX(AMAX), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .op_store(op_store1), .op_load(op_load1),
    .op_vector(op_vector), .base_addr(base_addr), .stride(stride),
    .lane_mask(lane_mask), .store_data(store_data), .mem_rdata(mem_rdata1),
    .stall(stall1), .mem_wen(mem_wen1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .load_vector(load_vector1), .addr_fault(addr_fault1)
  );

  // Word memories (byte address bits [11:2]), with a bench preload/clear port.
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic        clr, pre_we0, pre_we1;
  logic [9:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem0[i] <= 32'h0;
    end else if (pre_we0) mem0[pre_idx] <= pre_val;
    else if (mem_wen0) mem0[mem_addr0[11:2]] <= mem_wdata0;
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= 32'h0;
    end else if (pre_we1) mem1[pre_idx] <= pre_val;
    else if (mem_wen1) mem1[mem_addr1[11:2]] <= mem_wdata1;
    mem_rdata1 <= mem1[mem_addr1[11:2]];
  end

  assign mem_rdata0 = mem0[mem_addr0[11:2]];

  typedef struct {
    int           dut;
    string        tag;
    logic [31:0]  addr;
    bit           wen;
    bit           chk_wd;
    logic [31:0]  wdata;
    bit           stall;
    bit           fault;
    bit           chk_lv;
    logic [127:0] lv;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  exp_t         me;
  logic [31:0]  g_addr, g_wdata;
  logic         g_wen, g_stall, g_fault;
  logic [127:0] g_lv;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      if (me.dut == 0) begin
        g_addr = mem_addr0; g_wdata = mem_wdata0; g_wen = mem_wen0;
        g_stall = stall0; g_fault = addr_fault0; g_lv = load_vector0;
      end else begin
        g_addr = mem_addr1; g_wdata = mem_wdata1; g_wen = mem_wen1;
        g_stall = stall1; g_fault = addr_fault1; g_lv = load_vector1;
      end
      check_val({me.tag, ".addr"},  g_addr,  me.addr);
      check_val({me.tag, ".wen"},   g_wen,   me.wen);
      check_val({me.tag, ".stall"}, g_stall, me.stall);
      check_val({me.tag, ".fault"}, g_fault, me.fault);
      if (me.chk_wd) check_val({me.tag, ".wdata"}, g_wdata, me.wdata);
      if (me.chk_lv) check_val({me.tag, ".load_vector"}, g_lv, me.lv);
    end
  end

  task automatic push_exp(input int d, input string tag, input logic [31:0] addr,
                          input bit wen, input bit chk_wd, input logic [31:0] wdata,
                          input bit stl, input bit flt, input bit chk_lv,
                          input logic [127:0] lv);
    exp_t e;
    e.dut = d; e.tag = tag; e.addr = addr; e.wen = wen; e.chk_wd = chk_wd;
    e.wdata = wdata; e.stall = stl; e.fault = flt; e.chk_lv = chk_lv; e.lv = lv;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) until every expected cycle has been compared.
  task automatic wait_q(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check_val({tag, ".timeout"}, 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic preload(input int d, input logic [31:0] byte_addr, input logic [31:0] val);
    pre_idx = byte_addr[11:2];
    pre_val = val;
    if (d == 0) pre_we0 = 1'b1; else pre_we1 = 1'b1;
    @(posedge clk); #1;
    pre_we0 = 1'b0;
    pre_we1 = 1'b0;
  endtask

  task automatic drop_ops();
    op_store0 = 1'b0; op_load0 = 1'b0; op_store1 = 1'b0; op_load1 = 1'b0;
  endtask

  // Unit d (0: latency 0, 1: latency 1). Expected beats are derived from
  // addr_k = base + k*stride and the bench memory contents.
  task automatic run_op(input int d, input bit st, input bit vec,
                        input logic [31:0] base, input logic [31:0] strd,
                        input logic [3:0] mask, input logic [127:0] data,
                        input string name);
    int           nb;
    logic [127:0] lv;
    logic [31:0]  a [4];
    bit           f [4];
    bit           m [4];
    nb = vec ? 4 : 1;
    lv = '0;
    for (int k = 0; k < nb; k++) begin
      a[k] = base + strd * 32'(k);
      f[k] = (a[k] > AMAX);
      m[k] = vec ? mask[k] : 1'b1;
      if (!st && m[k] && !f[k])
        lv[k*32 +: 32] = (d == 0) ? mem0[a[k][11:2]] : mem1[a[k][11:2]];
    end
    for (int k = 0; k < nb; k++) begin
      push_exp(d, $sformatf("%s.b%0d", name, k), f[k] ? 32'h0 : a[k],
               st && m[k] && !f[k], st, vec ? data[k*32 +: 32] : data[31:0],
               (k < nb - 1) || (!st && d == 1), f[k],
               !st && d == 0 && k == nb - 1, lv);
    end
    if (!st && d == 1)
      push_exp(d, {name, ".drain"}, f[nb-1] ? 32'h0 : a[nb-1], 1'b0, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b1, lv);
    base_addr  = base;
    stride     = strd;
    lane_mask  = mask;
    store_data = data;
    op_vector  = vec;
    if (d == 0) begin op_store0 = st; op_load0 = !st; end
    else        begin op_store1 = st; op_load1 = !st; end
    wait_q(name);
    drop_ops();
    $display("txn %s: unit %0d %s %s base=%0h stride=%0h mask=%b", name, d,
             vec ? "vector" : "scalar", st ? "store" : "load", base, strd, mask);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; pre_we0 = 1'b0; pre_we1 = 1'b0; pre_idx = '0; pre_val = '0;
    // Requests asserted during reset must not leak to the outputs.
    op_store0 = 1'b1; op_load0 = 1'b0; op_store1 = 1'b0; op_load1 = 1'b1;
    op_vector = 1'b1; base_addr = 32'h100; stride = 32'h4; lane_mask = 4'hF;
    store_data = {4{32'h12345678}};
    push_exp(0, "reset_u0", 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 128'h0);
    push_exp(1, "reset_u1", 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 128'h0);
    wait_q("reset");
    $display("txn reset: outputs held at zero");
    drop_ops();
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    preload(0, 32'h200, 32'h5A);
    preload(0, 32'h3D088, 32'h11);
    preload(0, 32'h3D08C, 32'h22);
    preload(0, 32'h0, 32'hDEAD);      // what a clamped read returns
    preload(1, 32'h0, 32'h1);
    preload(1, 32'h4, 32'h2);
    preload(1, 32'h8, 32'h3);
    preload(1, 32'hC, 32'h4);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, 1'b1, 1'b1, 32'h100, 32'h4, 4'hF,
           {32'hDD, 32'hCC, 32'hBB, 32'hAA}, "unit_store");
    run_op(0, 1'b0, 1'b1, 32'h200, 32'h0, 4'hF, 128'h0, "bcast_load");
    run_op(0, 1'b1, 1'b1, 32'h40, 32'h10, 4'b0101,
           {32'h44, 32'h33, 32'h22, 32'h11}, "mask_store");
    check_val("mask_store.mem40", mem0[10'h010], 32'h11);
    check_val("mask_store.mem50", mem0[10'h014], 32'h0);
    check_val("mask_store.mem60", mem0[10'h018], 32'h33);
    check_val("mask_store.mem70", mem0[10'h01C], 32'h0);
    run_op(0, 1'b0, 1'b1, 32'h3D088, 32'h4, 4'hF, 128'h0, "clamp_load");
    run_op(1, 1'b0, 1'b1, 32'h0, 32'h4, 4'hF, 128'h0, "rl1_load");
    run_op(1, 1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 128'h0, "rl1_scalar_load");
    run_op(0, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0, {96'h0, 32'h77}, "scalar_store");
    check_val("scalar_store.mem500", mem0[10'h140], 32'h77);
    // Back-to-back with the scalar store: reads lanes written by unit_store.
    run_op(0, 1'b0, 1'b1, 32'h100, 32'h4, 4'b1010, 128'h0, "mask_load");

    // Reset in cycle 2 of a store aborts it.
    push_exp(0, "rst_mid.b0", 32'h300, 1'b1, 1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, 128'h0);
    push_exp(0, "rst_mid.b1", 32'h304, 1'b1, 1'b1, 32'hA1, 1'b1, 1'b0, 1'b0, 128'h0);
    push_exp(0, "rst_mid.c2", 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 128'h0);
    push_exp(0, "rst_mid.c3", 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 128'h0);
    base_addr = 32'h300; stride = 32'h4; lane_mask = 4'hF; op_vector = 1'b1;
    store_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    op_store0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drop_ops();
    wait_q("rst_mid");
    check_val("rst_mid.mem300", mem0[10'h0C0], 32'hA0);
    check_val("rst_mid.mem308", mem0[10'h0C2], 32'h0);
    check_val("rst_mid.mem30c", mem0[10'h0C3], 32'h0);
    $display("txn rst_mid: store aborted by reset in cycle 2");
    run_op(0, 1'b1, 1'b1, 32'h300, 32'h4, 4'hF,
           {32'hB3, 32'hB2, 32'hB1, 32'hB0}, "after_rst_store");
    check_val("after_rst_store.mem30c", mem0[10'h0C3], 32'hB3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
